// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset
// address, FSM encoding and the NOP used when the IF/ID register flushes.
package if_fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [2:0]  INST_BYTES       = 3'd4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Each 32-bit instruction is gathered as four
// byte reads over a byte-wide memory port with one cycle of read latency,
// assembled little-endian, then held for the IF/ID register until the
// downstream stage stops stalling. A branch/jump redirect discards the
// fetch in progress and restarts at the new target.
module if_fetch #(
    parameter int          XLEN     = if_fetch_pkg::XLEN,
    parameter logic [31:0] RESET_PC = if_fetch_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] br_pc,
    input  logic            br_e,
    input  logic            stl,
    input  logic            mem_busy,
    input  logic [7:0]      mem_din,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_re,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc,
    output logic            if_v
);
    import if_fetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [2:0]      bi_q,    bi_d;
    logic            pend_q,  pend_d;
    logic [1:0]      pidx_q,  pidx_d;
    logic [XLEN-1:0] buf_q,   buf_d;
    logic            ifv_q,   ifv_d;
    logic            issue;

    // Request a byte only while fetching, bytes remain, the arbiter is free
    // and no redirect is replacing the fetch address this cycle.
    always_comb begin
        issue    = !rst && (state_q == FETCH) && (bi_q < INST_BYTES)
                   && !mem_busy && !br_e;
        mem_re   = issue;
        mem_addr = pc_q + {{(XLEN-3){1'b0}}, bi_q};
        if_inst  = rst ? '0 : buf_q;
        if_pc    = rst ? '0 : pc_q;
        if_v     = !rst && ifv_q;
    end

    // Next-state logic: reset beats redirect, redirect beats fetch/hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bi_d    = bi_q;
        pend_d  = pend_q;
        pidx_d  = pidx_q;
        buf_d   = buf_q;
        ifv_d   = ifv_q;
        if (rst) begin
            state_d = FETCH;
            pc_d    = RESET_PC;
            bi_d    = 3'd0;
            pend_d  = 1'b0;
            pidx_d  = 2'd0;
            buf_d   = '0;
            ifv_d   = 1'b0;
        end else if (br_e) begin
            state_d = FETCH;
            pc_d    = br_pc;
            bi_d    = 3'd0;
            pend_d  = 1'b0;
            ifv_d   = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (issue) begin
                        pend_d = 1'b1;
                        pidx_d = bi_q[1:0];
                        bi_d   = bi_q + 3'd1;
                    end else begin
                        pend_d = 1'b0;
                    end
                    if (pend_q) begin
                        buf_d[8*pidx_q +: 8] = mem_din;
                        if (pidx_q == 2'd3) begin
                            state_d = HOLD;
                            ifv_d   = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stl) begin
                        pc_d    = pc_q + {{(XLEN-3){1'b0}}, INST_BYTES};
                        bi_d    = 3'd0;
                        ifv_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State register; all reset handling lives in the next-state logic.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        bi_q    <= bi_d;
        pend_q  <= pend_d;
        pidx_q  <= pidx_d;
        buf_q   <= buf_d;
        ifv_q   <= ifv_d;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [31:0] br_pc    = 32'h0;
    logic        br_e     = 1'b0;
    logic        stl      = 1'b0;
    logic        mem_busy = 1'b0;
    logic [7:0]  mem_din  = 8'h0;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_v;

    int checks   = 0;
    int failures = 0;

    // Model: where the current instruction lives, how many of its bytes
    // have been accepted, and whether it is being presented.
    logic [31:0] mPc        = 32'h0;
    int          mIssued    = 0;
    int          mCountdown = 0;
    bit          mHold      = 1'b0;

    if_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .br_pc    (br_pc),
        .br_e     (br_e),
        .stl      (stl),
        .mem_busy (mem_busy),
        .mem_din  (mem_din),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .if_v     (if_v)
    );

    always #5 clk = ~clk;

    // Memory contents: a NOP at address 0, a distinct byte pattern elsewhere.
    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [31:0] nop;
        nop = NOP_INST;
        if (a < 32'd4) return nop[8*a[1:0] +: 8];
        return (a[7:0] * 8'd7 + 8'd3) ^ a[15:8];
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return {memByte(a + 32'd3), memByte(a + 32'd2),
                memByte(a + 32'd1), memByte(a)};
    endfunction

    // Byte-wide memory with one cycle of read latency; garbage otherwise.
    always @(posedge clk) begin
        if (mem_re) mem_din <= memByte(mem_addr);
        else        mem_din <= 8'($urandom);
    end

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit expectRe();
        return !rst && !mHold && (mIssued < 4) && !mem_busy && !br_e;
    endfunction

    task automatic checkOutput();
        if (rst) begin
            checkVal("rst_mem_re",  32'(mem_re), 32'd0);
            checkVal("rst_if_v",    32'(if_v),   32'd0);
            checkVal("rst_if_inst", if_inst,     32'd0);
            checkVal("rst_if_pc",   if_pc,       32'd0);
        end else begin
            checkVal("mem_re",   32'(mem_re), 32'(expectRe()));
            checkVal("mem_addr", mem_addr,    mPc + 32'(mIssued));
            checkVal("if_v",     32'(if_v),   32'(mHold));
            if (mHold) begin
                checkVal("if_pc",   if_pc,   mPc);
                checkVal("if_inst", if_inst, wordAt(mPc));
            end
        end
    endtask

    task automatic modelStep();
        bit go;
        go = expectRe();
        if (rst) begin
            mPc = RESET_PC_DEFAULT; mIssued = 0; mCountdown = 0; mHold = 1'b0;
        end else if (br_e) begin
            mPc = br_pc; mIssued = 0; mCountdown = 0; mHold = 1'b0;
        end else if (mHold) begin
            if (!stl) begin
                mPc = mPc + 32'd4; mIssued = 0; mHold = 1'b0;
            end
        end else begin
            if (mCountdown > 0) begin
                mCountdown--;
                if (mCountdown == 0) mHold = 1'b1;
            end
            if (go) begin
                mIssued++;
                if (mIssued == 4) mCountdown = 1;
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, check, advance the model.
    task automatic applyStimulus(input bit r, input bit b, input logic [31:0] bpc,
                                 input bit busy, input bit s);
        @(negedge clk);
        rst = r; br_e = b; br_pc = bpc; mem_busy = busy; stl = s;
        #1;
        checkOutput();
        modelStep();
    endtask

    initial begin
        bit busySeq [8];
        busySeq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        // Fetch from reset: NOP at 0, next fetch at 4.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkVal("rf_addr", mem_addr, 32'(i));
            checkVal("rf_re", 32'(mem_re), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("rf_gap_re", 32'(mem_re), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("rf_v", 32'(if_v), 32'd1);
        checkVal("rf_inst", if_inst, 32'h0000_0013);
        checkVal("rf_pc", if_pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("rf_next_addr", mem_addr, 32'h4);
        checkVal("rf_next_re", 32'(mem_re), 32'd1);

        // Stall hold on the instruction at 4.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkVal("st_v", 32'(if_v), 32'd1);
            checkVal("st_pc", if_pc, 32'h4);
            checkVal("st_inst", if_inst, 32'h342D_261F);
            checkVal("st_re", 32'(mem_re), 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("st_next_addr", mem_addr, 32'h8);
        checkVal("st_next_re", 32'(mem_re), 32'd1);

        // Redirect to 0x200, then busy on bytes 1 and 3.
        applyStimulus(0, 1, 32'h200, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, busySeq[k], 0);
            if (k == 6) checkVal("bz_v_early", 32'(if_v), 32'd0);
        end
        checkVal("bz_v", 32'(if_v), 32'd1);
        checkVal("bz_inst", if_inst, 32'h1A13_0801);
        checkVal("bz_pc", if_pc, 32'h200);

        // Redirect to 0x100 the cycle after byte 1 of 0x204 issued.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h100, 0, 0);
        checkVal("rd_re", 32'(mem_re), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("rd_addr", mem_addr, 32'h100);
        checkVal("rd_re_next", 32'(mem_re), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("rd_v", 32'(if_v), 32'd1);
        checkVal("rd_pc", if_pc, 32'h100);

        // Redirect to 0x40 while stalled in hold.
        applyStimulus(0, 1, 32'h40, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("rh_v", 32'(if_v), 32'd0);
        checkVal("rh_addr", mem_addr, 32'h40);
        checkVal("rh_re", 32'(mem_re), 32'd1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset while byte 2 is pending.
        applyStimulus(1, 0, 0, 0, 0);
        checkVal("rm_re", 32'(mem_re), 32'd0);
        checkVal("rm_v", 32'(if_v), 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkVal("rm_addr", mem_addr, 32'h0);
        checkVal("rm_re_next", 32'(mem_re), 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic, including redirects near the top of memory.
        for (int n = 0; n < 4000; n++) begin
            bit          r, b, busy, s;
            logic [31:0] tgt;
            int          sel;
            r    = ($urandom_range(0, 99) == 0);
            b    = ($urandom_range(0, 99) < 4);
            busy = ($urandom_range(0, 99) < 30);
            s    = ($urandom_range(0, 99) < 40);
            sel  = $urandom_range(0, 9);
            if (sel == 0)      tgt = 32'hFFFF_FFFC;
            else if (sel == 1) tgt = 32'hFFFF_FFFE;
            else if (sel < 5)  tgt = {24'h0, 8'($urandom_range(0, 255))} & 32'hFFFF_FFFE;
            else               tgt = $urandom & 32'hFFFF_FFFE;
            applyStimulus(r, b, tgt, busy, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
